// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain initiator: issues a programmed number of ap_start handshakes,
// answers ap_done with ap_continue after a configurable hold, and measures
// per-transaction latency through a timestamp FIFO so several transactions
// can be in flight at once.
module ap_ctrl_chain_driver #(
   parameter int CNT_W        = 16,
   parameter int LAT_W        = 32,
   parameter int MAX_INFLIGHT = 4,
   parameter int DLY_W        = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_num_trans,
   input  logic [DLY_W-1:0] cfg_cont_delay,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] start_count,
   output logic [CNT_W-1:0] done_count,
   output logic [LAT_W-1:0] last_latency,
   output logic [LAT_W-1:0] max_latency,
   output logic             proto_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int OW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [OW-1:0] OCC_MAX  = OW'(MAX_INFLIGHT);
   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_INFLIGHT - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d, scnt_q, scnt_d, dcnt_q, dcnt_d;
   logic [DLY_W-1:0] dly_q, dly_d, wait_q, wait_d;
   logic [LAT_W-1:0] cyc_q, last_q, last_d, max_q, max_d;
   logic             start_q, start_d, perr_q, perr_d;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic [LAT_W-1:0] ts_q [MAX_INFLIGHT];

   logic             active, accept, complete, pop, cfg_load;
   logic [LAT_W-1:0] lat;

   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign active      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign ap_continue = active && ap_done && (wait_q == dly_q);
   assign accept      = active && start_q && ap_ready;
   assign complete    = ap_done && ap_continue;
   // A completion with nothing in the FIFO has no timestamp to pop.
   assign pop         = complete && (occ_q != '0);
   assign lat         = cyc_q - ts_q[rd_q];
   assign cfg_load    = cfg_valid && ((state_q == S_IDLE) || (state_q == S_FIN));

   // Next-state: run control, counters, FIFO bookkeeping and latency stats.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      dly_d   = dly_q;
      scnt_d  = scnt_q;
      dcnt_d  = dcnt_q;
      last_d  = last_q;
      max_d   = max_q;
      perr_d  = perr_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      occ_d   = occ_q;
      wait_d  = '0;
      start_d = 1'b0;

      if (accept) begin
         scnt_d = scnt_q + CNT_W'(1);
         wr_d   = ptr_nxt(wr_q);
      end
      if (complete) begin
         dcnt_d = dcnt_q + CNT_W'(1);
         if (pop) begin
            rd_d   = ptr_nxt(rd_q);
            last_d = lat;
            if (lat > max_q) max_d = lat;
         end else begin
            perr_d = 1'b1;
         end
      end
      case ({accept, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase

      // Hold counter only runs while ap_done waits for ap_continue.
      if (active && ap_done && !ap_continue) wait_d = wait_q + DLY_W'(1);

      case (state_q)
         S_IDLE, S_FIN: begin
            if (cfg_load) begin
               n_d     = cfg_num_trans;
               dly_d   = cfg_cont_delay;
               scnt_d  = '0;
               dcnt_d  = '0;
               last_d  = '0;
               max_d   = '0;
               perr_d  = 1'b0;
               wr_d    = '0;
               rd_d    = '0;
               occ_d   = '0;
               state_d = (cfg_num_trans == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN:   if (scnt_d == n_q) state_d = S_DRAIN;
         S_DRAIN: if (dcnt_d >= n_q) state_d = S_FIN;
         default: state_d = S_IDLE;
      endcase

      // A raised ap_start is held until ready; otherwise re-arm only when
      // another transaction is owed and a timestamp slot will be free.
      if (start_q && !ap_ready)
         start_d = 1'b1;
      else
         start_d = (state_q == S_RUN) && (scnt_d < n_q) && (occ_d < OCC_MAX);
   end

   // Control and status registers, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         dly_q   <= '0;
         scnt_q  <= '0;
         dcnt_q  <= '0;
         last_q  <= '0;
         max_q   <= '0;
         perr_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         occ_q   <= '0;
         wait_q  <= '0;
         start_q <= 1'b0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         dly_q   <= dly_d;
         scnt_q  <= scnt_d;
         dcnt_q  <= dcnt_d;
         last_q  <= last_d;
         max_q   <= max_d;
         perr_q  <= perr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         occ_q   <= occ_d;
         wait_q  <= wait_d;
         start_q <= start_d;
         cyc_q   <= cyc_q + LAT_W'(1);
      end
   end

   // Timestamp storage: cycle counter captured on each accepted start.
   always_ff @(posedge clock) begin
      if (accept) ts_q[wr_q] <= cyc_q;
   end

   assign ap_start     = start_q;
   assign busy         = active;
   assign finish       = (state_q == S_FIN);
   assign start_count  = scnt_q;
   assign done_count   = dcnt_q;
   assign last_latency = last_q;
   assign max_latency  = max_q;
   assign proto_err    = perr_q;

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Bench for ap_ctrl_chain_driver: a behavioural ap_ctrl_chain DUT model with
// programmable ready delay and pipeline latency, table-driven full runs and
// hand-written multi-cycle corner cases.
module tb_ap_ctrl_chain_driver;
   localparam int CNT_W = 16, LAT_W = 32, MAXF = 4, DLY_W = 4;

   logic             clock, reset, cfg_valid;
   logic [CNT_W-1:0] cfg_num_trans;
   logic [DLY_W-1:0] cfg_cont_delay;
   logic             ap_start, ap_ready, mdl_done, spur, ap_continue;
   logic             busy, finish, proto_err;
   logic [CNT_W-1:0] start_count, done_count;
   logic [LAT_W-1:0] last_latency, max_latency;

   ap_ctrl_chain_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W), .MAX_INFLIGHT(MAXF), .DLY_W(DLY_W)) dut (
      .clock(clock), .reset(reset), .cfg_valid(cfg_valid),
      .cfg_num_trans(cfg_num_trans), .cfg_cont_delay(cfg_cont_delay),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(mdl_done | spur),
      .ap_continue(ap_continue), .busy(busy), .finish(finish),
      .start_count(start_count), .done_count(done_count),
      .last_latency(last_latency), .max_latency(max_latency), .proto_err(proto_err));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int ncmp = 0, nerr = 0, viol = 0;
   int rdy_dly = 0, lat_l = 1;

   // DUT model: ap_ready after rdy_dly cycles of ap_start, ap_done lat_l
   // cycles after the accepting edge, held until ap_continue.
   int  due_q[$];
   int  k = 0, hc = 0;
   logic acc_s, cmp_s, st_s;
   initial begin
      ap_ready = 1'b0;
      mdl_done = 1'b0;
      forever begin
         @(negedge clock);
         acc_s = ap_start && ap_ready;
         cmp_s = (mdl_done | spur) && ap_continue;
         st_s  = ap_start;
         @(posedge clock);
         #1;
         k++;
         if (reset) begin
            due_q.delete();
            hc = 0;
         end else begin
            if (cmp_s && due_q.size() > 0 && due_q[0] < k) void'(due_q.pop_front());
            if (acc_s) begin
               due_q.push_back(k + lat_l - 1);
               hc = 0;
            end else if (st_s) hc++;
         end
         ap_ready = ap_start && (hc >= rdy_dly);
         mdl_done = (due_q.size() > 0) && (due_q[0] <= k);
      end
   end

   // Protocol monitor: ap_start never retracts before ready, in-flight <= MAXF.
   logic pst = 1'b0, prdy = 1'b0;
   always @(negedge clock) begin
      if (!reset && pst && !prdy && !ap_start) viol++;
      if (int'(start_count) - int'(done_count) > MAXF) viol++;
      pst  = ap_start;
      prdy = ap_ready;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Load a configuration; returns just after the edge that samples cfg_valid.
   task automatic run_cfg(input int n, input int d, input int rdy, input int lat);
      rdy_dly        = rdy;
      lat_l          = lat;
      cfg_num_trans  = CNT_W'(n);
      cfg_cont_delay = DLY_W'(d);
      cfg_valid      = 1'b1;
      tick();
      cfg_valid      = 1'b0;
   endtask

   task automatic wait_fin(input string nm);
      int i = 0;
      while (!finish && i < 3000) begin
         tick();
         i++;
      end
      chk(nm, finish, 1);
   endtask

   task automatic wait_sig_start(input string nm);
      int i = 0;
      while (!ap_start && i < 100) begin
         tick();
         i++;
      end
      chk(nm, ap_start, 1);
   endtask

   task automatic wait_sig_done(input string nm);
      int i = 0;
      while (!(mdl_done | spur) && i < 100) begin
         tick();
         i++;
      end
      chk(nm, mdl_done | spur, 1);
   endtask

   typedef struct {
      int n; int d; int rdy; int lat;
      int e_start; int e_done; int e_last; int e_max;
   } vec_t;
   vec_t vt[6];

   initial begin
      // n  d  rdy lat  start done last max
      vt[0] = '{3, 0, 0,  1,  3, 3,  1,  1};
      vt[1] = '{1, 0, 5,  1,  1, 1,  1,  1};
      vt[2] = '{2, 2, 0,  1,  2, 2,  5,  5};
      vt[3] = '{8, 0, 0, 10,  8, 8, 10, 10};
      vt[4] = '{5, 0, 2,  3,  5, 5,  3,  3};
      vt[5] = '{0, 0, 0,  1,  0, 0,  0,  0};

      reset = 1'b1; cfg_valid = 1'b0; spur = 1'b0;
      cfg_num_trans = '0; cfg_cont_delay = '0;
      tick(); tick();
      chk("rst_start", ap_start, 0);
      chk("rst_cont", ap_continue, 0);
      chk("rst_busy", busy, 0);
      chk("rst_finish", finish, 0);
      chk("rst_scnt", start_count, 0);
      chk("rst_maxlat", max_latency, 0);
      reset = 1'b0;
      tick();

      // N=0 from IDLE: finish one cycle after cfg_valid, never a start.
      chk("n0_pre_finish", finish, 0);
      run_cfg(0, 0, 0, 1);
      chk("n0_finish", finish, 1);
      chk("n0_busy", busy, 0);
      tick(); tick();
      chk("n0_start", ap_start, 0);
      chk("n0_scnt", start_count, 0);

      // Table-driven full runs, each restarted from FINISH.
      foreach (vt[i]) begin
         run_cfg(vt[i].n, vt[i].d, vt[i].rdy, vt[i].lat);
         if (vt[i].n != 0) begin
            chk($sformatf("v%0d_finish_drop", i), finish, 0);
            chk($sformatf("v%0d_busy_run", i), busy, 1);
         end
         wait_fin($sformatf("v%0d_finish", i));
         chk($sformatf("v%0d_busy", i), busy, 0);
         chk($sformatf("v%0d_scnt", i), start_count, vt[i].e_start);
         chk($sformatf("v%0d_dcnt", i), done_count, vt[i].e_done);
         chk($sformatf("v%0d_last", i), last_latency, vt[i].e_last);
         chk($sformatf("v%0d_max", i), max_latency, vt[i].e_max);
         chk($sformatf("v%0d_perr", i), proto_err, 0);
         tick();
      end

      // ap_ready held low 5 cycles: ap_start held, dropped after accept.
      run_cfg(1, 0, 5, 1);
      wait_sig_start("rdy_start_rise");
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rdy_hold%0d", i), {ap_start, ap_ready}, 2'b10);
         tick();
      end
      chk("rdy_accept", {ap_start, ap_ready}, 2'b11);
      tick();
      chk("rdy_drop", ap_start, 0);
      chk("rdy_scnt", start_count, 1);
      wait_fin("rdy_finish");

      // D=2 with ap_done held: continue only on the 3rd ap_done cycle.
      run_cfg(1, 2, 0, 1);
      wait_sig_done("d2_done_rise");
      chk("d2_cont_c1", ap_continue, 0);
      tick();
      chk("d2_cont_c2", ap_continue, 0);
      tick();
      chk("d2_cont_c3", ap_continue, 1);
      chk("d2_dcnt_before", done_count, 0);
      tick();
      chk("d2_dcnt_after", done_count, 1);
      chk("d2_cont_after", ap_continue, 0);
      wait_fin("d2_finish");
      chk("d2_dcnt_final", done_count, 1);

      // Pipelined DUT, latency 10: starts stall at 4 in flight.
      run_cfg(8, 0, 0, 10);
      for (int i = 0; i < 10; i++) tick();
      chk("pipe_stall_scnt", start_count, 4);
      chk("pipe_stall_dcnt", done_count, 0);
      chk("pipe_stall_start", ap_start, 0);
      wait_fin("pipe_finish");
      chk("pipe_last", last_latency, 10);
      chk("pipe_max", max_latency, 10);

      // cfg_valid during RUN is ignored.
      run_cfg(2, 0, 0, 20);
      tick();
      cfg_num_trans = '0;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("ign_busy", busy, 1);
      chk("ign_finish", finish, 0);
      wait_fin("ign_finish_end");
      chk("ign_scnt", start_count, 2);
      chk("ign_dcnt", done_count, 2);

      // Spurious ap_done before any accept, then async reset mid-RUN.
      run_cfg(3, 0, 1000, 1);
      tick(); tick(); tick();
      spur = 1'b1;
      tick();
      spur = 1'b0;
      chk("spur_perr", proto_err, 1);
      chk("spur_dcnt", done_count, 1);
      chk("spur_scnt", start_count, 0);
      chk("spur_last", last_latency, 0);
      chk("spur_busy", busy, 1);
      chk("spur_start_high", ap_start, 1);
      reset = 1'b1;
      #1;
      chk("arst_start", ap_start, 0);
      chk("arst_busy", busy, 0);
      chk("arst_perr", proto_err, 0);
      chk("arst_dcnt", done_count, 0);
      chk("arst_cont", ap_continue, 0);
      tick();
      reset = 1'b0;
      tick();

      chk("protocol_violations", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/ap_ctrl_chain_driver.md
Name: ap_ctrl_chain_driver

Overview:
Synthesizable initiator for the HLS block-level ap_ctrl_chain handshake. It drives ap_start/ap_continue into a DUT (e.g. the divider) and consumes its ap_ready/ap_done for a programmed number of transactions. It measures per-transaction latency through a timestamp FIFO, which allows pipelined DUTs with several transactions in flight. It raises finish once all transactions have completed. It sits in the testbench/top opposite the dataflow status monitors, which observe the same four signals.

Parameters:
CNT_W, 16, width of transaction count and counters
LAT_W, 32, width of cycle timestamp and latency results
MAX_INFLIGHT, 4, timestamp FIFO depth (power of 2, >=1); maximum started-but-not-completed transactions
DLY_W, 4, width of continue back-pressure delay

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  one-cycle pulse that loads the configuration and starts a run
cfg_num_trans  in  CNT_W  number of transactions to issue
cfg_cont_delay  in  DLY_W  cycles ap_done must be held before ap_continue is given
ap_start  out  1  to DUT
ap_ready  in  1  from DUT
ap_done  in  1  from DUT
ap_continue  out  1  to DUT
busy  out  1  run in progress
finish  out  1  all transactions complete
start_count  out  CNT_W  accepted starts (ap_start&&ap_ready)
done_count  out  CNT_W  completions (ap_done&&ap_continue)
last_latency  out  LAT_W  latency of the most recent completion
max_latency  out  LAT_W  largest latency this run
proto_err  out  1  sticky flag: completion with empty FIFO

Behaviour:
- Reset (async, any time including mid-run): state IDLE, FIFO empty, cycle counter=0. All outputs 0; ap_start and ap_continue drop immediately.
- States:
  - IDLE: on cfg_valid, latch cfg_num_trans to N and cfg_cont_delay to D, and clear counts, latencies and proto_err. If N==0, go to FINISH; else go to RUN.
  - RUN: issue starts. When start_count reaches N, go to DRAIN.
  - DRAIN: wait until done_count==N, then go to FINISH.
  - FINISH: finish=1 and held. cfg_valid restarts the run exactly as from IDLE, and finish drops the next cycle.
- busy=1 in RUN and DRAIN. cfg_valid is ignored in RUN and DRAIN.
- ap_start (registered):
  - Rises when in RUN, start_count+pending<N, and the FIFO is not full.
  - Once high, it stays high until the cycle ap_ready=1 is sampled. It never retracts before ap_ready.
  - Accept = ap_start&&ap_ready. Each accept increments start_count and pushes the cycle counter into the FIFO.
  - ap_start may remain high across back-to-back accepts when the next transaction is eligible, giving one start per cycle.
- ap_continue (combinational):
  - ap_continue = ap_done && (wait_cnt==D).
  - wait_cnt increments each cycle that ap_done=1 and ap_continue=0. It clears on completion or when ap_done=0.
  - D=0 gives ap_continue in the same cycle as ap_done.
  - ap_continue is 0 in IDLE and FINISH.
- Completion = ap_done&&ap_continue:
  - Increments done_count and pops the FIFO.
  - last_latency = cycle_counter - popped timestamp, modulo 2^LAT_W (wrap-safe subtraction).
  - max_latency is updated if the new latency is larger.
  - Latency of a start accepted at cycle t and done at cycle t+k equals k.
- Simultaneous push and pop in one cycle is legal; FIFO occupancy is unchanged.
- Completion with an empty FIFO:
  - Sets proto_err (sticky until next cfg_valid).
  - Still counts done_count.
  - Leaves the latencies unchanged.
- FIFO full: ap_start is not raised (or re-raised) until a pop occurs. Occupancy never exceeds MAX_INFLIGHT.
- Cycle counter is free-running from reset and wraps naturally.
- Counters saturate at no point: N fits in CNT_W by construction.

Test Plan:
- Single-cycle DUT model (ap_ready=ap_done one cycle after start), N=3, D=0:
  - start_count=done_count=3.
  - last_latency=max_latency=1.
  - finish high; busy low.
- DUT holds ap_ready low 5 cycles, N=1: ap_start stays high all 5 cycles and drops the cycle after the accept.
- D=2, ap_done held: ap_continue asserts on the 3rd ap_done cycle only, and done_count increments once.
- Pipelined DUT (latency 10, II=1), N=8, MAX_INFLIGHT=4:
  - FIFO occupancy never exceeds 4.
  - Starts stall after 4 accepts until the first done.
  - All latencies equal 10 and finish goes high.
- N=0 pulse:
  - finish=1 one cycle after cfg_valid.
  - No ap_start.
  - cfg_valid during RUN is ignored.
- Spurious ap_done before any start: proto_err=1, done_count=1. Async reset mid-RUN clears all outputs immediately, without waiting for a clock edge.
